lfsr_checker: RTL

Receive-side pseudo-random bit sequence checker paired with the LFSR generator datapath. It takes the serial bit stream the generator emits, self-synchronises a local shift register to it, and predicts each following bit. It counts checked bits and mismatches so a lab bench or on-board display can report link bit-error rate. It sits after the serial link or loopback, with the same start/stop control style as the generator's control FSM.

---
 rtl/lfsr_pkg.sv | 14 +
 rtl/lfsr_checker_sat_counter.sv | 35 +++
 rtl/lfsr_checker.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: checker state encoding and the default polynomial,
// kept in one place so the generator and checker always agree.
package lfsr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FILL  = 2'b01,
        ST_CHECK = 2'b11
    } chk_state_e;

    localparam int         LFSR_WIDTH = 8;
    localparam logic [7:0] LFSR_TAPS  = 8'hB8;

endpackage

// File: rtl/lfsr_checker_sat_counter.sv
// Saturating up-counter with synchronous clear, used for the bit and error tallies.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear beats increment; once all ones the count sticks.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising PRBS checker: fills a local shift register from the line,
// then predicts each bit and tallies mismatches. Optional LFSR_CHK_RESYNC_EN refills after a burst of errors.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int               WIDTH       = LFSR_WIDTH,
    parameter logic [WIDTH-1:0] TAPS        = WIDTH'(LFSR_TAPS),
    parameter int               CNT_W       = 16,
    parameter int               RESYNC_ERRS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             din,
    input  logic             din_valid,
    output logic             running,
    output logic             filling,
    output logic             err_pulse,
    output logic             stuck,
    output logic [CNT_W-1:0] bit_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int                FILL_W    = $clog2(WIDTH + 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WIDTH);

    chk_state_e        state_q, state_d;
    logic [WIDTH-1:0]  sr_q, sr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              err_pulse_q, err_pulse_d;
    logic              running_q, filling_q, stuck_q;
    logic              bit_inc, err_inc, cnt_clr;
    logic              exp_bit;

`ifdef LFSR_CHK_RESYNC_EN
    localparam int                CONS_W    = $clog2(RESYNC_ERRS + 1);
    localparam logic [CONS_W-1:0] CONS_LAST = CONS_W'(RESYNC_ERRS);
    logic [CONS_W-1:0] cons_q, cons_d;
`endif

    assign exp_bit = ^(sr_q & TAPS);

    // Stop has priority over start in every state; idle ignores the line.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        fill_d      = fill_q;
        err_pulse_d = 1'b0;
        bit_inc     = 1'b0;
        err_inc     = 1'b0;
        cnt_clr     = 1'b0;
`ifdef LFSR_CHK_RESYNC_EN
        cons_d      = cons_q;
`endif
        if (stop) begin
            state_d = ST_IDLE;
        end else if (start) begin
            state_d = ST_FILL;
            sr_d    = '0;
            fill_d  = '0;
            cnt_clr = 1'b1;
`ifdef LFSR_CHK_RESYNC_EN
            cons_d  = '0;
`endif
        end else if (din_valid) begin
            case (state_q)
                ST_FILL: begin
                    sr_d   = {sr_q[WIDTH-2:0], din};
                    fill_d = fill_q + 1'b1;
                    if (fill_d == FILL_LAST) begin
                        state_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    // The received bit, not the prediction, is shifted in so one line error heals itself.
                    sr_d    = {sr_q[WIDTH-2:0], din};
                    bit_inc = 1'b1;
`ifdef LFSR_CHK_RESYNC_EN
                    cons_d  = '0;
`endif
                    if (din != exp_bit) begin
                        err_inc     = 1'b1;
                        err_pulse_d = 1'b1;
`ifdef LFSR_CHK_RESYNC_EN
                        cons_d = cons_q + 1'b1;
                        if (cons_d == CONS_LAST) begin
                            state_d = ST_FILL;
                            fill_d  = '0;
                            cons_d  = '0;
                        end
`else
                        state_d = ST_CHECK;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            fill_q      <= '0;
            err_pulse_q <= 1'b0;
            running_q   <= 1'b0;
            filling_q   <= 1'b0;
            stuck_q     <= 1'b0;
`ifdef LFSR_CHK_RESYNC_EN
            cons_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            err_pulse_q <= err_pulse_d;
            running_q   <= (state_d == ST_CHECK);
            filling_q   <= (state_d == ST_FILL);
            stuck_q     <= (state_d == ST_CHECK) && (sr_d == '0);
`ifdef LFSR_CHK_RESYNC_EN
            cons_q      <= cons_d;
`endif
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_bit_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (bit_inc),
        .count (bit_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (err_inc),
        .count (err_count)
    );

    assign running   = running_q;
    assign filling   = filling_q;
    assign err_pulse = err_pulse_q;
    assign stuck     = stuck_q;

endmodule
